// File: rtl/pool_pkg.sv
// Shared constants, FSM encoding and window packing for the 2x2 pooling window gatherer.
// Byte lane k of a packed window holds one pixel of the 2x2 block: 0=top-left, 3=bottom-right.
package pool_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int POOL_SIZE     = 4;
    localparam int MAX_FM_WIDTH  = 64;
    localparam int DIM_WIDTH     = 8;

    localparam int WIN_WIDTH     = POOL_SIZE * DATA_WIDTH;
    localparam int LB_DEPTH      = MAX_FM_WIDTH / 2;
    localparam int LB_ADDR_WIDTH = $clog2(LB_DEPTH);
    localparam int LB_WIDTH      = 2 * DATA_WIDTH;

    localparam int BYTE_TL = 0;
    localparam int BYTE_TR = 1;
    localparam int BYTE_BL = 2;
    localparam int BYTE_BR = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ROW_TOP = 2'd1;
    localparam logic [1:0] ST_ROW_BOT = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ROW_TOP = ST_ROW_TOP,
        ROW_BOT = ST_ROW_BOT,
        DRAIN   = ST_DRAIN
    } pool_state_e;

    function automatic logic [WIN_WIDTH-1:0] pack_window(
        input logic [DATA_WIDTH-1:0] tl,
        input logic [DATA_WIDTH-1:0] tr,
        input logic [DATA_WIDTH-1:0] bl,
        input logic [DATA_WIDTH-1:0] br
    );
        logic [WIN_WIDTH-1:0] w;
        w = '0;
        w[BYTE_TL*DATA_WIDTH +: DATA_WIDTH] = tl;
        w[BYTE_TR*DATA_WIDTH +: DATA_WIDTH] = tr;
        w[BYTE_BL*DATA_WIDTH +: DATA_WIDTH] = bl;
        w[BYTE_BR*DATA_WIDTH +: DATA_WIDTH] = br;
        return w;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Simple dual-port line buffer holding one even row as pixel pairs {odd col, even col}.
// Registered read; the read data holds its value until the next read is issued.
module pool_line_buffer
    import pool_pkg::*;
(
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [LB_ADDR_WIDTH-1:0] wr_addr,
    input  logic [LB_WIDTH-1:0]      wr_data,
    input  logic                     rd_en,
    input  logic [LB_ADDR_WIDTH-1:0] rd_addr,
    output logic [LB_WIDTH-1:0]      rd_data
);

    logic [LB_WIDTH-1:0] mem [0:LB_DEPTH-1];
    logic [LB_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/pool_window_gather.sv
// Gathers non-overlapping 2x2 windows from a raster pixel stream into packed 32-bit words.
// Even rows are parked in the line buffer; odd rows combine with them to emit one window per pixel pair.
module pool_window_gather
    import pool_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  fm_width,
    input  logic [DIM_WIDTH-1:0]  fm_height,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [WIN_WIDTH-1:0]  win_data,
    output logic                  busy,
    output logic                  frame_done
);

    logic [1:0]            state_reg, state_next;
    logic [DIM_WIDTH-1:0]  width_reg, width_next;
    logic [DIM_WIDTH-1:0]  height_reg, height_next;
    logic [DIM_WIDTH-1:0]  col_reg, col_next;
    logic [DIM_WIDTH-1:0]  row_reg, row_next;
    logic [DATA_WIDTH-1:0] stage_reg, stage_next;
    logic                  win_valid_reg, win_valid_next;
    logic [WIN_WIDTH-1:0]  win_data_reg, win_data_next;
    logic                  frame_done_reg, frame_done_next;

    logic                  pix_ready_c;
    logic                  pix_fire;
    logic                  last_col;
    logic                  last_row;
    logic                  col_has_pair;
    logic                  row_has_pair;
    logic                  lb_wr_en;
    logic                  lb_rd_en;
    logic                  win_load;
    logic [LB_WIDTH-1:0]   lb_rd_data;
    logic [LB_ADDR_WIDTH-1:0] lb_addr;

    // Bottom rows stall only when the single output slot is occupied and not draining.
    always_comb begin
        pix_ready_c = 1'b0;
        case (state_reg)
            ST_ROW_TOP: pix_ready_c = 1'b1;
            ST_ROW_BOT: pix_ready_c = !win_valid_reg || win_ready;
            default:    pix_ready_c = 1'b0;
        endcase
    end

    assign pix_fire     = pix_valid && pix_ready_c;
    assign last_col     = (col_reg == width_reg - DIM_WIDTH'(1));
    assign last_row     = (row_reg == height_reg - DIM_WIDTH'(1));
    // A trailing odd column or row has no partner and is swallowed.
    assign col_has_pair = ({1'b0, col_reg} + 9'd1) < {1'b0, width_reg};
    assign row_has_pair = ({1'b0, row_reg} + 9'd1) < {1'b0, height_reg};
    assign lb_addr      = col_reg[LB_ADDR_WIDTH:1];

    assign lb_wr_en = pix_fire && (state_reg == ST_ROW_TOP) && col_reg[0] && row_has_pair;
    assign lb_rd_en = pix_fire && (state_reg == ST_ROW_BOT) && !col_reg[0] && col_has_pair;
    assign win_load = pix_fire && (state_reg == ST_ROW_BOT) && col_reg[0];

    pool_line_buffer u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data ({pix_data, stage_reg}),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    always_comb begin
        state_next      = state_reg;
        width_next      = width_reg;
        height_next     = height_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    width_next  = fm_width;
                    height_next = fm_height;
                    col_next    = '0;
                    row_next    = '0;
                    state_next  = ST_ROW_TOP;
                end
            end
            ST_ROW_TOP, ST_ROW_BOT: begin
                if (pix_fire) begin
                    if (last_col) begin
                        col_next = '0;
                        row_next = row_reg + DIM_WIDTH'(1);
                        if (last_row) begin
                            state_next = ST_DRAIN;
                        end else if (state_reg == ST_ROW_TOP) begin
                            state_next = ST_ROW_BOT;
                        end else begin
                            state_next = ST_ROW_TOP;
                        end
                    end else begin
                        col_next = col_reg + DIM_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!win_valid_reg || win_ready) begin
                    frame_done_next = 1'b1;
                    state_next      = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stage_next     = stage_reg;
        win_valid_next = win_valid_reg;
        win_data_next  = win_data_reg;
        if (pix_fire && !col_reg[0]) begin
            stage_next = pix_data;
        end
        if (win_load) begin
            win_valid_next = 1'b1;
            win_data_next  = pack_window(lb_rd_data[DATA_WIDTH-1:0],
                                         lb_rd_data[LB_WIDTH-1:DATA_WIDTH],
                                         stage_reg, pix_data);
        end else if (win_ready) begin
            win_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            width_reg      <= '0;
            height_reg     <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            stage_reg      <= '0;
            win_valid_reg  <= 1'b0;
            win_data_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            width_reg      <= width_next;
            height_reg     <= height_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            stage_reg      <= stage_next;
            win_valid_reg  <= win_valid_next;
            win_data_reg   <= win_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign pix_ready  = pix_ready_c;
    assign win_valid  = win_valid_reg;
    assign win_data   = win_data_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = frame_done_reg;

endmodule

// File: doc/pool_window_gather.md
Name: pool_window_gather

Overview:
Upstream feeder for the 2x2 max-pooling stage. It accepts a raster-order stream of signed 8-bit feature-map pixels, one row at a time, and buffers each even row in a line buffer. It then assembles every non-overlapping 2x2 window (stride 2) into one 32-bit packed word, which is exactly the operand format the pooling comparator tree consumes. The output is a valid/ready stream with one window per two pixels accepted on odd rows.

Parameters:
DATA_WIDTH, 8, pixel width in bits (signed)
POOL_SIZE, 4, pixels per window (2x2; fixed, not re-scalable)
MAX_FM_WIDTH, 64, largest supported feature-map width in pixels (even)
DIM_WIDTH, 8, bit width of fm_width / fm_height configuration inputs

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
fm_width  in  DIM_WIDTH  frame width in pixels, latched on start, range 2..MAX_FM_WIDTH
fm_height  in  DIM_WIDTH  frame height in pixels, latched on start, minimum 2
pix_valid  in  1  input pixel valid
pix_ready  out  1  input pixel accepted when pix_valid && pix_ready
pix_data  in  DATA_WIDTH  signed pixel
win_valid  out  1  packed window valid
win_ready  in  1  downstream accepts window
win_data  out  POOL_SIZE*DATA_WIDTH  {p(r+1,c+1), p(r+1,c), p(r,c+1), p(r,c)}, byte 0 = top-left
busy  out  1  high from the cycle after start is accepted until frame_done
frame_done  out  1  one-cycle pulse when the last window of the frame is handshaken

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE; pix_ready=0, win_valid=0, win_data=0, busy=0, frame_done=0; row/col counters=0. Line buffer contents are not cleared (don't-care). Reset mid-frame abandons the frame; no frame_done is produced.
- FSM states:
  - IDLE: pix_ready=0. start latches the dimensions and moves to ROW_TOP.
  - ROW_TOP (even row): pix_ready=1. Even column: pixel goes to a staging register. Odd column: {pixel, staging} is written as one 16-bit word to line buffer address col/2.
  - ROW_BOT (odd row): even column: pixel goes to a staging register and line buffer read of address col/2 is issued (registered read, data held until the next read). Odd column: the window is formed from the line-buffer word, staging and the current pixel, and loaded into the output register.
  - DRAIN: waits for the final window handshake, then pulses frame_done and returns to IDLE.
- pix_ready in ROW_BOT = !win_valid || win_ready (single-entry output register, full throughput when downstream is ready).
- Latency: win_valid rises the cycle after the odd-column pixel of an odd row is accepted. win_data is stable while win_valid && !win_ready.
- Counters: col wraps to 0 at fm_width-1 and advances row; the state toggles ROW_TOP/ROW_BOT on each row wrap.
- Floor semantics for odd dimensions:
  - Odd fm_width: the last column is accepted and discarded (no write, no window).
  - Odd fm_height: the last row is accepted and discarded (treated as ROW_TOP with writes suppressed).
- End of frame: acceptance of the last pixel (row fm_height-1, col fm_width-1) moves to DRAIN. If no window is pending, frame_done pulses next cycle.
- start while busy is ignored. Dimensions outside the legal range give undefined output but must not hang after reset.
- Pixel data is passed through bit-exact; no arithmetic and no sign change.

Decomposition:
- Package pool_pkg: DATA_WIDTH, POOL_SIZE, window packing byte-order constants, and a state enum typedef {IDLE, ROW_TOP, ROW_BOT, DRAIN}.
- One sub-module, pool_line_buffer: MAX_FM_WIDTH/2 x 2*DATA_WIDTH simple dual-port RAM with synchronous write and registered read.

Test Plan:
- 4x4 frame, pixels 1..16 raster order, win_ready=1 -> windows 0x06050201, 0x08070403, 0x0E0D0A09, 0x100F0C0B in order, then a single frame_done pulse.
- Same frame with win_ready held low for 5 cycles after the first win_valid -> win_data holds 0x06050201, pix_ready=0 on row 1 while blocked, and no window is lost or duplicated.
- 5x3 frame, pixels 1..15 -> exactly 2 windows, 0x07060201 and 0x09080403; column 4 and row 2 are consumed; frame_done fires after the 15th pixel's drain.
- Signed values: row0 = 0x80,0x7F; row1 = 0xFF,0x00 (2x2 frame) -> win_data = 0x00FF7F80.
- Assert rst mid-row 1 of a 4x4 frame -> next cycle all outputs are at reset values, busy=0, no frame_done; a new start then yields a correct full frame.
- Pulse start while busy -> ignored; the dimensions latched at the original start stay in effect.
